// File: rtl/wb_timer_if.sv
// Wishbone-classic bus bundle for the wb_timer register block (8-bit data, 4-bit address).
interface wb_timer_if;
    logic       wb_cyc_i;
    logic       wb_stb_i;
    logic       wb_we_i;
    logic [3:0] wb_adr_i;
    logic [7:0] wb_dat_i;
    logic [7:0] wb_dat_o;
    logic       wb_ack_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wb_timer.sv
// Wishbone-classic 16-bit down-counter timer with 8-bit prescaler and level interrupt.
// Optional coherent high-byte read shadow: define WB_TIMER_SNAPSHOT_EN.
module wb_timer (
    input  logic      clk,
    input  logic      rst_n,
    wb_timer_if.slave bus,
    output logic      irq_o
);
    localparam logic [3:0] AdrCtrl   = 4'd0;
    localparam logic [3:0] AdrStatus = 4'd1;
    localparam logic [3:0] AdrPre    = 4'd2;
    localparam logic [3:0] AdrRldL   = 4'd3;
    localparam logic [3:0] AdrRldH   = 4'd4;
    localparam logic [3:0] AdrCntL   = 4'd5;
    localparam logic [3:0] AdrCntH   = 4'd6;

    logic        en_q, en_d, per_q, per_d, ie_q, ie_d, exp_q, exp_d;
    logic [7:0]  pre_q, pre_d, rld_l_q, rld_l_d, rld_h_q, rld_h_d;
    logic [7:0]  presc_q, presc_d;
    logic [15:0] count_q, count_d;
    logic        ack_q, ack_d;
    logic [7:0]  dat_q, dat_d;
    logic [7:0]  rdata;
    logic        req, wr, rd, tick, load, expire;
`ifdef WB_TIMER_SNAPSHOT_EN
    logic [7:0]  shadow_q, shadow_d;
`endif

    // A held strobe is masked while ack is high, so back-to-back accesses ack every 2nd cycle.
    assign req    = bus.wb_cyc_i & bus.wb_stb_i & ~ack_q;
    assign wr     = req & bus.wb_we_i;
    assign rd     = req & ~bus.wb_we_i;
    assign load   = wr & (bus.wb_adr_i == AdrRldH);
    assign tick   = en_q & (presc_q == 8'd0);
    // A same-cycle reload discards the tick, so no expiry either.
    assign expire = tick & (count_q == 16'd0) & ~load;

    always_comb begin
        rdata = 8'h00;
        case (bus.wb_adr_i)
            AdrCtrl:   rdata = {5'b0, ie_q, per_q, en_q};
            AdrStatus: rdata = {7'b0, exp_q};
            AdrPre:    rdata = pre_q;
            AdrRldL:   rdata = rld_l_q;
            AdrRldH:   rdata = rld_h_q;
            AdrCntL:   rdata = count_q[7:0];
`ifdef WB_TIMER_SNAPSHOT_EN
            AdrCntH:   rdata = shadow_q;
`else
            AdrCntH:   rdata = count_q[15:8];
`endif
            default:   rdata = 8'h00;
        endcase
    end

    always_comb begin
        en_d    = en_q;
        per_d   = per_q;
        ie_d    = ie_q;
        exp_d   = exp_q;
        pre_d   = pre_q;
        rld_l_d = rld_l_q;
        rld_h_d = rld_h_q;
        presc_d = presc_q;
        count_d = count_q;
        ack_d   = req;
        dat_d   = rd ? rdata : 8'h00;
`ifdef WB_TIMER_SNAPSHOT_EN
        shadow_d = (rd && bus.wb_adr_i == AdrCntL) ? count_q[15:8] : shadow_q;
`endif

        if (load) begin
            count_d = {bus.wb_dat_i, rld_l_q};
            presc_d = pre_q;
        end else if (en_q) begin
            presc_d = (presc_q == 8'd0) ? pre_q : presc_q - 8'd1;
            if (tick) begin
                if (count_q != 16'd0) begin
                    count_d = count_q - 16'd1;
                end else if (per_q) begin
                    count_d = {rld_h_q, rld_l_q};
                end else begin
                    en_d = 1'b0;
                end
            end
        end

        // Clear first so that a same-cycle expiry wins.
        if (wr && bus.wb_adr_i == AdrStatus && bus.wb_dat_i[0]) begin
            exp_d = 1'b0;
        end
        if (expire) begin
            exp_d = 1'b1;
        end

        if (wr) begin
            case (bus.wb_adr_i)
                AdrCtrl: begin
                    en_d  = bus.wb_dat_i[0];
                    per_d = bus.wb_dat_i[1];
                    ie_d  = bus.wb_dat_i[2];
                end
                AdrPre:  pre_d   = bus.wb_dat_i;
                AdrRldL: rld_l_d = bus.wb_dat_i;
                AdrRldH: rld_h_d = bus.wb_dat_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q    <= 1'b0;
            per_q   <= 1'b0;
            ie_q    <= 1'b0;
            exp_q   <= 1'b0;
            pre_q   <= 8'h00;
            rld_l_q <= 8'h00;
            rld_h_q <= 8'h00;
            presc_q <= 8'h00;
            count_q <= 16'h0000;
            ack_q   <= 1'b0;
            dat_q   <= 8'h00;
        end else begin
            en_q    <= en_d;
            per_q   <= per_d;
            ie_q    <= ie_d;
            exp_q   <= exp_d;
            pre_q   <= pre_d;
            rld_l_q <= rld_l_d;
            rld_h_q <= rld_h_d;
            presc_q <= presc_d;
            count_q <= count_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
        end
    end

`ifdef WB_TIMER_SNAPSHOT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= 8'h00;
        end else begin
            shadow_q <= shadow_d;
        end
    end
`endif

    assign bus.wb_ack_o = ack_q;
    assign bus.wb_dat_o = dat_q;
    assign irq_o        = exp_q & ie_q;
endmodule

// File: tb/tb_wb_timer.sv
// Directed self-checking bench for wb_timer: reset, one-shot, periodic, set/clear race,
// bus handshake and high-byte snapshot behaviour.
module tb_wb_timer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic irq_o;
    int   n_checks = 0;
    int   n_fail = 0;

    wb_timer_if bus ();

    wb_timer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .irq_o (irq_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Accepted at the next edge; returns #1 after the following edge with ack low.
    task automatic wb_write(input logic [3:0] adr, input logic [7:0] d);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b1;
        bus.wb_adr_i = adr;
        bus.wb_dat_i = d;
        tick_n(1);
        check_eq("wr_ack", {15'd0, bus.wb_ack_o}, 16'd1);
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        tick_n(1);
    endtask

    task automatic wb_read(input logic [3:0] adr, output logic [7:0] d);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = adr;
        tick_n(1);
        check_eq("rd_ack", {15'd0, bus.wb_ack_o}, 16'd1);
        d = bus.wb_dat_o;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        tick_n(1);
        check_eq("dat_idle", {8'd0, bus.wb_dat_o}, 16'd0);
    endtask

    task automatic read_check(input string tag, input logic [3:0] adr, input logic [7:0] exp);
        logic [7:0] d;
        wb_read(adr, d);
        check_eq(tag, {8'd0, d}, {8'd0, exp});
    endtask

    initial begin
        logic [7:0] hs_exp [4];
        logic       ak_exp [4];
        int         waited;
        hs_exp = '{8'h5A, 8'h00, 8'h5A, 8'h00};
        ak_exp = '{1'b1, 1'b0, 1'b1, 1'b0};

        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = 4'd0;
        bus.wb_dat_i = 8'd0;

        // Reset state.
        tick_n(3);
        check_eq("rst_ack", {15'd0, bus.wb_ack_o}, 16'd0);
        check_eq("rst_dat", {8'd0, bus.wb_dat_o}, 16'd0);
        check_eq("rst_irq", {15'd0, irq_o}, 16'd0);
        rst_n = 1'b1;
        tick_n(1);
        for (int a = 0; a < 7; a++) read_check("rst_reg", 4'(a), 8'h00);

        // One-shot: count 3 with P=0 expires on the 4th tick after en.
        wb_write(4'd2, 8'h00);
        wb_write(4'd3, 8'h03);
        wb_write(4'd4, 8'h00);
        wb_write(4'd0, 8'h05);
        tick_n(2);
        check_eq("os_irq_early", {15'd0, irq_o}, 16'd0);
        tick_n(1);
        check_eq("os_irq_rise", {15'd0, irq_o}, 16'd1);
        read_check("os_ctrl", 4'd0, 8'h04);
        read_check("os_status", 4'd1, 8'h01);
        read_check("os_cnt_l", 4'd5, 8'h00);
        read_check("os_cnt_h", 4'd6, 8'h00);
        tick_n(5);
        read_check("os_cnt_hold", 4'd5, 8'h00);

        // Periodic, P=2, reload 1: ticks every 3 clocks, expiry every 6.
        wb_write(4'd0, 8'h00);
        wb_write(4'd1, 8'h01);
        check_eq("irq_cleared", {15'd0, irq_o}, 16'd0);
        wb_write(4'd2, 8'h02);
        wb_write(4'd3, 8'h01);
        wb_write(4'd4, 8'h00);
        wb_write(4'd0, 8'h03);
        check_eq("per_cnt_a1", dut.count_q, 16'd1);
        tick_n(1);
        check_eq("per_cnt_a2", dut.count_q, 16'd1);
        check_eq("per_exp_a2", {15'd0, dut.exp_q}, 16'd0);
        tick_n(1);
        check_eq("per_cnt_a3", dut.count_q, 16'd0);
        tick_n(2);
        check_eq("per_exp_a5", {15'd0, dut.exp_q}, 16'd0);
        tick_n(1);
        check_eq("per_cnt_a6", dut.count_q, 16'd1);
        check_eq("per_exp_a6", {15'd0, dut.exp_q}, 16'd1);

        // Clear-vs-set race; expiries fall on A+12 and A+18.
        wb_write(4'd0, 8'h07);
        check_eq("race_irq_ie", {15'd0, irq_o}, 16'd1);
        wb_write(4'd1, 8'h01);
        check_eq("race_irq_clr", {15'd0, irq_o}, 16'd0);
        check_eq("per_cnt_a10", dut.count_q, 16'd0);
        tick_n(1);
        wb_write(4'd1, 8'h01);
        check_eq("race_set_wins", {15'd0, irq_o}, 16'd1);
        wb_write(4'd1, 8'h01);
        check_eq("race_late_clr", {15'd0, irq_o}, 16'd0);
        read_check("race_status", 4'd1, 8'h00);

        // Bus handshake with held strobe.
        wb_write(4'd0, 8'h00);
        wb_write(4'd1, 8'h01);
        wb_write(4'd2, 8'h5A);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = 4'd2;
        for (int i = 0; i < 4; i++) begin
            tick_n(1);
            check_eq("hs_ack", {15'd0, bus.wb_ack_o}, {15'd0, ak_exp[i]});
            check_eq("hs_dat", {8'd0, bus.wb_dat_o}, {8'd0, hs_exp[i]});
        end
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        tick_n(1);
        wb_write(4'hF, 8'hFF);
        read_check("unmapped", 4'hF, 8'h00);

        // High-byte snapshot: CNT_L read at 0x0100, CNT_H read after rollover to 0x00FF.
        wb_write(4'd2, 8'h00);
        wb_write(4'd3, 8'h00);
        wb_write(4'd4, 8'h01);
        read_check("snap_cnt_l", 4'd5, 8'h00);
        wb_write(4'd0, 8'h01);
`ifdef WB_TIMER_SNAPSHOT_EN
        read_check("snap_cnt_h", 4'd6, 8'h01);
`else
        read_check("snap_cnt_h", 4'd6, 8'h00);
`endif
        read_check("snap_live_l", 4'd5, 8'hFD);

        // Async reset mid-access with ack and irq high.
        wb_write(4'd0, 8'h00);
        wb_write(4'd3, 8'h02);
        wb_write(4'd4, 8'h00);
        wb_write(4'd0, 8'h05);
        waited = 0;
        while (irq_o !== 1'b1 && waited < 20) begin
            tick_n(1);
            waited++;
        end
        check_eq("rst_irq_pre", {15'd0, irq_o}, 16'd1);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = 4'd2;
        tick_n(1);
        check_eq("rst_mid_ack_pre", {15'd0, bus.wb_ack_o}, 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_ack", {15'd0, bus.wb_ack_o}, 16'd0);
        check_eq("rst_mid_dat", {8'd0, bus.wb_dat_o}, 16'd0);
        check_eq("rst_mid_irq", {15'd0, irq_o}, 16'd0);
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        tick_n(2);
        rst_n = 1'b1;
        tick_n(1);
        for (int a = 0; a < 7; a++) read_check("rst2_reg", 4'(a), 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
